// File: rtl/ms_timer.sv
// ms_timer -- millisecond countdown timer fed by the CPU register file.
//
// A rising edge on start arms the timer with time_ms milliseconds; start
// held low aborts a run and clears the done flag and any pending interrupt.
// done/busy/interrupt are registered and decoded from the next state, so
// done rises exactly time_ms*CYCLES_PER_MS edges after the edge that sees
// the start rise.
//
// Compile-time option: define MS_TIMER_AUTO_RELOAD_EN to add the
// auto_reload input (periodic mode). Without it the timer is one-shot.
module ms_timer #(
   parameter int CLK_FREQ_HZ = 27000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] time_ms,
   input  logic        start,
   input  logic        interrupt_enable,
   input  logic        interrupt_ack,
`ifdef MS_TIMER_AUTO_RELOAD_EN
   input  logic        auto_reload,
`endif
   output logic        done,
   output logic        busy,
   output logic        interrupt
);

   // Prescaler terminal count. CLK_FREQ_HZ is expected to be >= 1000; the
   // clamp keeps the counter well formed if a smaller value slips through.
   localparam int CYCLES_RAW    = CLK_FREQ_HZ / 1000;
   localparam int CYCLES_PER_MS = (CYCLES_RAW < 1) ? 1 : CYCLES_RAW;
   localparam int PRE_W         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

   localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);

   // FSM encoding; 2'b11 is unused and recovers to IDLE.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // Registered state
   logic [1:0]       state;
   logic             start_q;
   logic [PRE_W-1:0] prescaler;
   logic [15:0]      ms_left;

   // Next-state values
   logic [1:0]       state_nxt;
   logic [PRE_W-1:0] prescaler_nxt;
   logic [15:0]      ms_left_nxt;
   logic             irq_set;
   logic             done_nxt;
   logic             busy_nxt;
   logic             interrupt_nxt;

   // Decoded helpers
   logic             start_rise;
   logic             pre_wrap;
   logic             last_ms;

`ifdef MS_TIMER_AUTO_RELOAD_EN
   // Periodic mode: duration captured at the start rise, and a done flag
   // that survives reloads until start drops.
   logic [15:0]      reload_val;
   logic [15:0]      reload_val_nxt;
   logic             done_sticky;
   logic             done_sticky_nxt;
`endif

   // Edge detect and terminal-count decode, shared by the FSM below.
   always_comb begin
      start_rise = start & ~start_q;
      pre_wrap   = (prescaler == PRE_LAST);
      last_ms    = (ms_left == 16'd1);
   end

   // Next-state, prescaler and millisecond counter logic.
   always_comb begin
      state_nxt     = state;
      prescaler_nxt = prescaler;
      ms_left_nxt   = ms_left;
      irq_set       = 1'b0;
`ifdef MS_TIMER_AUTO_RELOAD_EN
      reload_val_nxt  = reload_val;
      done_sticky_nxt = done_sticky;
`endif

      if (!start) begin
         // Start low wins from any state: abort a run or clear done.
         state_nxt     = ST_IDLE;
         prescaler_nxt = PRE_ZERO;
`ifdef MS_TIMER_AUTO_RELOAD_EN
         done_sticky_nxt = 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_rise) begin
`ifdef MS_TIMER_AUTO_RELOAD_EN
                  reload_val_nxt = time_ms;
`endif
                  if (time_ms == 16'd0) begin
                     // Zero duration expires immediately; nothing to count.
                     state_nxt = ST_DONE;
                     irq_set   = interrupt_enable;
                  end else begin
                     state_nxt     = ST_RUNNING;
                     ms_left_nxt   = time_ms;
                     prescaler_nxt = PRE_ZERO;
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end

            ST_RUNNING: begin
               if (pre_wrap) begin
                  prescaler_nxt = PRE_ZERO;
                  if (last_ms) begin
                     // Expiry. interrupt_enable is only looked at here.
                     irq_set = interrupt_enable;
`ifdef MS_TIMER_AUTO_RELOAD_EN
                     if (auto_reload) begin
                        // reload_val is never 0 here: a zero request goes
                        // straight from IDLE to DONE.
                        state_nxt       = ST_RUNNING;
                        ms_left_nxt     = reload_val;
                        done_sticky_nxt = 1'b1;
                     end else begin
                        state_nxt   = ST_DONE;
                        ms_left_nxt = 16'd0;
                     end
`else
                     state_nxt   = ST_DONE;
                     ms_left_nxt = 16'd0;
`endif
                  end else begin
                     // ms_left >= 2 here, so no underflow is possible.
                     ms_left_nxt = ms_left - 16'd1;
                  end
               end else begin
                  prescaler_nxt = prescaler + PRE_ONE;
               end
            end

            ST_DONE: begin
               // Hold until start drops; a fresh rise is needed to re-arm.
               state_nxt = ST_DONE;
            end

            default: begin
               // Unreachable encoding: return to a clean idle.
               state_nxt     = ST_IDLE;
               prescaler_nxt = PRE_ZERO;
               ms_left_nxt   = 16'd0;
            end
         endcase
      end
   end

   // Output decode from the next state so flags line up with the transition.
   always_comb begin
      busy_nxt = (state_nxt == ST_RUNNING);
`ifdef MS_TIMER_AUTO_RELOAD_EN
      done_nxt = (state_nxt == ST_DONE) | done_sticky_nxt;
`else
      done_nxt = (state_nxt == ST_DONE);
`endif
      if (irq_set) begin
         // A set in the same cycle as an ack takes priority.
         interrupt_nxt = 1'b1;
      end else if (interrupt_ack || !start) begin
         interrupt_nxt = 1'b0;
      end else begin
         interrupt_nxt = interrupt;
      end
   end

   // State, counters and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         start_q   <= 1'b0;
         prescaler <= PRE_ZERO;
         ms_left   <= 16'd0;
         done      <= 1'b0;
         busy      <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         state     <= state_nxt;
         start_q   <= start;
         prescaler <= prescaler_nxt;
         ms_left   <= ms_left_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         interrupt <= interrupt_nxt;
      end
   end

`ifdef MS_TIMER_AUTO_RELOAD_EN
   // Periodic-mode reload value and sticky done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_val  <= 16'd0;
         done_sticky <= 1'b0;
      end else begin
         reload_val  <= reload_val_nxt;
         done_sticky <= done_sticky_nxt;
      end
   end
`endif

endmodule
